bluejay_register_file: RTL and testbench
========================================

# bluejay_register_file

Integer register file for the 64-bit RISC-V core: 32 architectural registers of 64 bits, two combinational read ports and one synchronous write port. It sits in the decode/execute stages and supplies the rs1/rs2 operands. It accepts the rd result from writeback. Register x0 is hardwired to zero.

## Interface
Parameters:
- None. Geometry is fixed at 32 entries × 64 bits with a 5-bit address.

Ports:
- Clocking and reset: one clock; reset is synchronous and active-high (ports `clk`, `rst`).
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `we`  in  1  write enable for the write port.
- `wr_addr`  in  5  write register index.
- `wr_data`  in  64  write data.
- `rd_addr_0`  in  5  read port 0 index (rs1).
- `rd_data_0`  out  64  read port 0 data.
- `rd_addr_1`  in  5  read port 1 index (rs2).
- `rd_data_1`  out  64  read port 1 data.

## Operation
- Storage: registers x1..x31, 64 bits each. x0 has no storage.
- Write: on a rising `clk` edge, if `we`=1 and `rst`=0 and `wr_addr`≠0, then reg[`wr_addr`] ← `wr_data`.
- Writes to x0 are silently discarded.
- Reset: on a rising edge with `rst`=1, x1..x31 ← 0.
  - Reset has priority over a simultaneous write; the write is dropped.
- Reset mid-operation: the clear takes effect at the first rising edge where `rst` is sampled high. Writes on earlier edges complete normally.
- Read: each port is purely combinational.
  - `rd_data_N` = 0 if `rd_addr_N`=0, else reg[`rd_addr_N`].
- Both read ports are independent. They may address the same register, and both return identical data.
- Same-cycle read/write of the same nonzero register is governed by the Configuration section.
- No X propagation: all outputs are defined from the first reset onward.

## Timing
- Read latency: 0 cycles (combinational, address → data).
- Write latency: 1 edge. Data is visible on the read ports in the cycle after the write edge.
- Reset: all read ports return 0 from the cycle following the reset edge.
  - Before the first reset, register contents are undefined, except that x0 always reads 0.
- No handshake. `we` is sampled only at rising edges.

## Configuration
- Macro `REGFILE_WRITE_BYPASS_EN`.
- Defined: a read port whose `rd_addr_N` equals `wr_addr` (nonzero) while `we`=1 and `rst`=0 returns `wr_data` combinationally in the same cycle (write-through forwarding).
  - x0 still reads 0.
  - During `rst`=1 no bypass occurs.
- Undefined: reads return the stored (pre-write) value in that cycle. The new value appears after the edge.

## Test plan
- Reset clear: write 0xDEAD_BEEF to x5, then assert `rst` for 1 cycle → `rd_data_0`/`rd_data_1` read 0 for x5 and for every address 0..31.
- Write/read all: write 64'h1111_0000_0000_0000 + i to xi for i=1..31, then read all via both ports → each returns its value; x0 returns 0.
- x0 immunity: `we`=1, `wr_addr`=0, `wr_data`=all-ones → `rd_addr_0`=0 still reads 0.
- Reset priority: `rst`=1 and `we`=1 to x7 with 0x1234 on the same edge → x7 reads 0 afterwards.
- Same-cycle hazard: x9 holds 0xAAAA; drive `we`=1, `wr_addr`=9, `wr_data`=0x5555, `rd_addr_1`=9 → with bypass defined, 0x5555 before the edge; without it, 0xAAAA before the edge. In both builds, 0x5555 after the edge.
- Dual port: x3=0x3 and x4=0x4; `rd_addr_0`=3, `rd_addr_1`=4, then swap → outputs follow the addresses in 0 cycles; both ports on x3 → both 0x3.

Source files
------------

// File: rtl/bluejay_register_file_if.sv
// bluejay_register_file_if
//   Bundles the register-file access signals: one write port and two
//   combinational read ports.
//
//   we        write enable, sampled at the rising clock edge
//   wr_addr   write register index (x0 writes are discarded)
//   wr_data   write data
//   rd_addr_0 read port 0 index (rs1)   -> rd_data_0
//   rd_addr_1 read port 1 index (rs2)   -> rd_data_1
//
//   master: the pipeline side (drives indices/write data)
//   slave : the register file (returns read data)
interface bluejay_register_file_if;
  logic        we;
  logic [4:0]  wr_addr;
  logic [63:0] wr_data;
  logic [4:0]  rd_addr_0;
  logic [63:0] rd_data_0;
  logic [4:0]  rd_addr_1;
  logic [63:0] rd_data_1;

  modport master (
    output we, wr_addr, wr_data, rd_addr_0, rd_addr_1,
    input  rd_data_0, rd_data_1
  );

  modport slave (
    input  we, wr_addr, wr_data, rd_addr_0, rd_addr_1,
    output rd_data_0, rd_data_1
  );
endinterface

// File: rtl/bluejay_register_file.sv
// bluejay_register_file
//   Integer register file of the 64-bit RISC-V core: x1..x31 of 64 bits,
//   x0 hardwired to zero. Two combinational read ports (rs1/rs2) and one
//   synchronous write port (rd from writeback).
//
// Ports
//   clk  : clock, all state updates on the rising edge
//   rst  : synchronous active-high reset, clears x1..x31 and wins over
//          a write on the same edge
//   rf   : bluejay_register_file_if.slave (we, wr_addr, wr_data,
//          rd_addr_0/rd_data_0, rd_addr_1/rd_data_1)
//
// Build option
//   REGFILE_WRITE_BYPASS_EN : when defined, a read of the register being
//   written in the current cycle returns wr_data combinationally
//   (write-through). When undefined, the read returns the stored value and
//   the new value appears after the edge.
module bluejay_register_file (
  input  logic                     clk,
  input  logic                     rst,
  bluejay_register_file_if.slave   rf
);

  // Flop-based storage: the read ports are asynchronous and reset must
  // clear every entry in one edge, which block RAM cannot provide.
  logic [63:0] regs_reg [1:31];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < 32; i++) begin
        regs_reg[i] <= '0;
      end
    end else if (rf.we) begin
      // The loop starts at 1, so a write to x0 matches no entry.
      for (int i = 1; i < 32; i++) begin
        if (rf.wr_addr == 5'(i)) begin
          regs_reg[i] <= rf.wr_data;
        end
      end
    end
  end

  logic [1:0][4:0] rd_addr;
  assign rd_addr[0] = rf.rd_addr_0;
  assign rd_addr[1] = rf.rd_addr_1;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd_port
      logic [63:0] rd_value;

      always_comb begin
        // Default of zero covers x0, which has no storage.
        rd_value = '0;
        for (int i = 1; i < 32; i++) begin
          if (rd_addr[gi] == 5'(i)) begin
            rd_value = regs_reg[i];
          end
        end
`ifdef REGFILE_WRITE_BYPASS_EN
        // Forward the in-flight write; suppressed during reset because
        // that write will be dropped.
        if (!rst && rf.we && (rf.wr_addr != 5'd0) &&
            (rf.wr_addr == rd_addr[gi])) begin
          rd_value = rf.wr_data;
        end
`endif
      end
    end
  endgenerate

  assign rf.rd_data_0 = g_rd_port[0].rd_value;
  assign rf.rd_data_1 = g_rd_port[1].rd_value;

endmodule

// File: tb/tb_bluejay_register_file.sv
// tb_bluejay_register_file
//   Directed self-checking bench for bluejay_register_file. Works for both
//   builds; the same-cycle hazard expectation follows
//   REGFILE_WRITE_BYPASS_EN.
module tb_bluejay_register_file;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  bluejay_register_file_if rf_if ();

  bluejay_register_file dut (
    .clk (clk),
    .rst (rst),
    .rf  (rf_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One write transaction: inputs change on the falling edge, the write
  // commits on the following rising edge.
  task automatic write_reg(input logic [4:0] addr, input logic [63:0] data);
    @(negedge clk);
    rf_if.we      = 1'b1;
    rf_if.wr_addr = addr;
    rf_if.wr_data = data;
    @(negedge clk);
    rf_if.we      = 1'b0;
    $display("write x%0d <= %h", addr, data);
  endtask

  // Read one address on both ports and compare against the same value.
  task automatic read_both(input string tag, input logic [4:0] addr,
                           input logic [63:0] exp);
    rf_if.rd_addr_0 = addr;
    rf_if.rd_addr_1 = addr;
    #1;
    check({tag, "_p0"}, rf_if.rd_data_0, exp);
    check({tag, "_p1"}, rf_if.rd_data_1, exp);
    $display("read x%0d both ports, expect %h", addr, exp);
  endtask

  logic [63:0] exp_val;

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    rf_if.we        = 1'b0;
    rf_if.wr_addr   = '0;
    rf_if.wr_data   = '0;
    rf_if.rd_addr_0 = '0;
    rf_if.rd_addr_1 = '0;

    // Initial reset.
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int a = 0; a < 32; a++) read_both("init_rst", 5'(a), 64'h0);

    // Reset clear after a write.
    write_reg(5'd5, 64'h0000_0000_DEAD_BEEF);
    read_both("x5_written", 5'd5, 64'h0000_0000_DEAD_BEEF);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int a = 0; a < 32; a++) read_both("rst_clear", 5'(a), 64'h0);

    // Write every register, read all back through both ports.
    for (int a = 1; a < 32; a++)
      write_reg(5'(a), 64'h1111_0000_0000_0000 + 64'(a));
    read_both("all_x0", 5'd0, 64'h0);
    for (int a = 1; a < 32; a++)
      read_both("all", 5'(a), 64'h1111_0000_0000_0000 + 64'(a));

    // x0 immunity: check during the write cycle and after the edge.
    @(negedge clk);
    rf_if.we        = 1'b1;
    rf_if.wr_addr   = 5'd0;
    rf_if.wr_data   = '1;
    rf_if.rd_addr_0 = 5'd0;
    #1;
    check("x0_during_write", rf_if.rd_data_0, 64'h0);
    @(negedge clk);
    rf_if.we = 1'b0;
    $display("write x0 <= all-ones (discarded)");
    read_both("x0_after_write", 5'd0, 64'h0);

    // Reset priority over a simultaneous write to x7.
    @(negedge clk);
    rst           = 1'b1;
    rf_if.we      = 1'b1;
    rf_if.wr_addr = 5'd7;
    rf_if.wr_data = 64'h1234;
    @(negedge clk);
    rst      = 1'b0;
    rf_if.we = 1'b0;
    $display("reset + write x7 <= 1234 on same edge");
    read_both("rst_prio_x7", 5'd7, 64'h0);
    read_both("rst_prio_x8", 5'd8, 64'h0);

    // Same-cycle read/write hazard on x9.
    write_reg(5'd9, 64'hAAAA);
    @(negedge clk);
    rf_if.we        = 1'b1;
    rf_if.wr_addr   = 5'd9;
    rf_if.wr_data   = 64'h5555;
    rf_if.rd_addr_1 = 5'd9;
    rf_if.rd_addr_0 = 5'd8;
    #1;
`ifdef REGFILE_WRITE_BYPASS_EN
    exp_val = 64'h5555;
`else
    exp_val = 64'hAAAA;
`endif
    check("hazard_before_edge", rf_if.rd_data_1, exp_val);
    check("hazard_other_port", rf_if.rd_data_0, 64'h0);
    @(posedge clk);
    #1;
    check("hazard_after_edge", rf_if.rd_data_1, 64'h5555);
    @(negedge clk);
    rf_if.we = 1'b0;
    $display("write x9 <= 5555 with concurrent read");

    // No forwarding while reset is high; stored value shows until the edge.
    @(negedge clk);
    rst             = 1'b1;
    rf_if.we        = 1'b1;
    rf_if.wr_addr   = 5'd9;
    rf_if.wr_data   = 64'h7777;
    rf_if.rd_addr_1 = 5'd9;
    #1;
    check("rst_no_bypass", rf_if.rd_data_1, 64'h5555);
    @(negedge clk);
    rst      = 1'b0;
    rf_if.we = 1'b0;
    $display("reset + write x9 <= 7777 with concurrent read");
    read_both("rst_cleared_x9", 5'd9, 64'h0);

    // Dual port independence.
    write_reg(5'd3, 64'h3);
    write_reg(5'd4, 64'h4);
    rf_if.rd_addr_0 = 5'd3;
    rf_if.rd_addr_1 = 5'd4;
    #1;
    check("dual_p0_x3", rf_if.rd_data_0, 64'h3);
    check("dual_p1_x4", rf_if.rd_data_1, 64'h4);
    rf_if.rd_addr_0 = 5'd4;
    rf_if.rd_addr_1 = 5'd3;
    #1;
    check("swap_p0_x4", rf_if.rd_data_0, 64'h4);
    check("swap_p1_x3", rf_if.rd_data_1, 64'h3);
    read_both("same_x3", 5'd3, 64'h3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
